fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 191 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch_queue, the instruction memory and the decode stage.
// master = fetch_queue side, slave = environment (memory + consumer) side.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] perf_stall_count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, perf_stall_count,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, perf_stall_count,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: single-outstanding memory requester feeding a DEPTH-entry buffer.
// Optional stall counter enabled by defining FETCH_PERF_COUNT_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  fetch_queue_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     inst_pc_q, inst_pc_d;
  logic [31:0]     mem_pc   [DEPTH];
  logic [31:0]     mem_data [DEPTH];

  logic            req_out;
  logic            ack_s;
  logic            push_s;
  logic            pop_s;
  logic            valid_s;
  logic [CW-1:0]   remain_s;

  // An ack is only meaningful while a request is actually outstanding
  assign ack_s   = bus.imem_ack && (state_q != ST_IDLE);
  assign push_s  = ack_s && (state_q == ST_WAIT) && !bus.redirect;
  assign valid_s = (count_q != '0) && !bus.redirect;
  assign pop_s   = valid_s && bus.inst_ready;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.redirect)            state_d = ST_WAIT;
        else if (count_q < DEPTH_C)  state_d = ST_WAIT;
        else                         state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (bus.redirect)            state_d = ack_s ? ST_WAIT : ST_DROP;
        else if (ack_s)              state_d = (count_d < DEPTH_C) ? ST_WAIT : ST_IDLE;
        else                         state_d = ST_WAIT;
      end
      ST_DROP: begin
        if (ack_s)                   state_d = ST_WAIT;
        else                         state_d = ST_DROP;
      end
      default:                       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_out = 1'b0;
    case (state_q)
      ST_WAIT, ST_DROP: req_out = 1'b1;
      default:          req_out = 1'b0;
    endcase
  end

  // Fetch PC, occupancy and pointer updates
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & ~32'h0000_0003;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (push_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d   = wr_ptr_q;
      end
      if (pop_s) rd_ptr_d = rd_ptr_q + PW'(1);
      else       rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Request address is latched per request so it stays stable through DROP
  always_comb begin
    if (state_d == ST_WAIT) addr_d = fetch_pc_d;
    else                    addr_d = addr_q;
  end

  // Head-of-buffer output registers; they hold their value while empty
  always_comb begin
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    remain_s  = pop_s ? (count_q - CW'(1)) : count_q;
    if (bus.redirect) begin
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
    end else if (push_s && (remain_s == '0)) begin
      inst_d    = bus.imem_rdata;
      inst_pc_d = fetch_pc_q;
    end else if (remain_s != '0) begin
      inst_d    = mem_data[rd_ptr_d];
      inst_pc_d = mem_pc[rd_ptr_d];
    end else begin
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inst_q     <= 32'h0000_0000;
      inst_pc_q  <= 32'h0000_0000;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  // Buffer storage; contents are only read behind a valid count
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_pc[wr_ptr_q]   <= fetch_pc_q;
      mem_data[wr_ptr_q] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] perf_q, perf_d;

  // Saturating starvation counter, untouched by redirect
  always_comb begin
    if (bus.inst_ready && !valid_s && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
    else                                                          perf_d = perf_q;
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= 32'h0000_0000;
    else       perf_q <= perf_d;
  end

  assign bus.perf_stall_count = perf_q;
`else
  assign bus.perf_stall_count = 32'h0000_0000;
`endif

  assign bus.imem_req   = req_out;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_s;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a latency-programmable memory model and an
// expected-instruction queue filled on accepted acks and drained on pops.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;
  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d;
  } ent_t;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 0;
  int          wcnt;
  logic        force_ack = 1'b0;
  logic        mon_en    = 1'b0;
  ent_t        sb[$];
  logic [31:0] m_pc;
  logic        m_stale;
  int          m_stall;
  int          n_ack;
  logic [31:0] last_ack_addr;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return ~a ^ 32'h3C3C_0F0F;
  endfunction

  // memory model: ack once the request has waited lat cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else                                   wcnt <= 0;
  end
  assign bus.imem_ack   = force_ack || (bus.imem_req && (wcnt >= lat));
  assign bus.imem_rdata = data_of(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_pc     = RESET_PC;
    m_stale  = 1'b0;
    m_stall  = 0;
    n_ack    = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = RESET_PC;
  endtask

  task automatic model_step();
    ent_t e;
    logic exp_valid;
    exp_valid = (sb.size() != 0) && !bus.redirect;
    chk("valid", 32'(bus.inst_valid), 32'(exp_valid));
`ifdef FETCH_PERF_COUNT_EN
    chk("perf", bus.perf_stall_count, 32'(m_stall));
`else
    chk("perf", bus.perf_stall_count, 32'h0);
`endif
    if (bus.inst_ready && !exp_valid) m_stall++;
    if (prev_req && !prev_ack && bus.imem_req) chk("addr_hold", bus.imem_addr, prev_addr);
    prev_req  = bus.imem_req;
    prev_ack  = bus.imem_ack;
    prev_addr = bus.imem_addr;
    if (bus.redirect) begin
      sb.delete();
      m_stale = bus.imem_req && !bus.imem_ack;
      m_pc    = bus.redirect_pc & ~32'h3;
    end else begin
      if (exp_valid && bus.inst_ready) begin
        e = sb.pop_front();
        chk("inst_pc", bus.inst_pc, e.pc);
        chk("inst", bus.inst, e.d);
      end
      if (bus.imem_req && bus.imem_ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          chk("imem_addr", bus.imem_addr, m_pc);
          sb.push_back('{m_pc, data_of(m_pc)});
          last_ack_addr = bus.imem_addr;
          m_pc = m_pc + 32'd4;
          n_ack++;
          chk("no_overflow", 32'(sb.size() <= DEPTH), 32'h1);
        end
      end
    end
  endtask

  // per-cycle scoreboard step, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en && !reset) model_step();
  end

  task automatic reset_dut(input int l, input logic rdy);
    mon_en          = 1'b0;
    reset           = 1'b1;
    lat             = l;
    bus.inst_ready  = rdy;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.inst_valid) return;
    end
    chk({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic wait_fresh_req(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.imem_req && !bus.imem_ack && wcnt == 0) return;
    end
    chk({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    @(posedge clk); #1;
    bus.redirect    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    model_clear();
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_pc", bus.inst_pc, 32'h0);
    chk("rst_perf", bus.perf_stall_count, 32'h0);

    // zero-wait streaming: one instruction per cycle, first two cycles after release
    reset_dut(0, 1'b1);
    chk("idle_req", 32'(bus.imem_req), 32'h0);
    @(posedge clk); #1;
    chk("first_req", 32'(bus.imem_req), 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("stream_valid", 32'(bus.inst_valid), 32'h1);
      chk("stream_pc", bus.inst_pc, 32'(4 * k));
    end

    // consumer stalled: buffer fills to DEPTH, then a single pop allows one refill
    reset_dut(0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("fill_count", 32'(n_ack), 32'(DEPTH));
    chk("fill_req", 32'(bus.imem_req), 32'h0);
    bus.inst_ready = 1'b1;
    @(posedge clk); #1;
    bus.inst_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("refill_count", 32'(n_ack), 32'(DEPTH + 1));
    chk("refill_addr", last_ack_addr, 32'h10);
    chk("refill_req", 32'(bus.imem_req), 32'h0);

    // redirect while a slow request is pending: stale data dropped
    reset_dut(2, 1'b1);
    wait_fresh_req("drop");
    pulse_redirect(32'h0000_0103);
    chk("drop_addr_stable", 32'(bus.imem_req), 32'h1);
    wait_valid("drop");
    chk("drop_first_pc", bus.inst_pc, 32'h100);

    // redirect coincident with the ack for 0x8
    reset_dut(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.imem_ack && bus.imem_addr == 32'h8) break;
    end
    chk("coinc_addr", bus.imem_addr, 32'h8);
    pulse_redirect(32'h0000_0040);
    chk("coinc_next_addr", bus.imem_addr, 32'h40);
    wait_valid("coinc");
    chk("coinc_first_pc", bus.inst_pc, 32'h40);

    // second redirect while in DROP retargets the restart address
    reset_dut(3, 1'b1);
    wait_fresh_req("drop2");
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    @(posedge clk); #1;
    bus.redirect_pc = 32'h0000_0302;
    @(posedge clk); #1;
    bus.redirect    = 1'b0;
    wait_valid("drop2");
    chk("drop2_first_pc", bus.inst_pc, 32'h300);

    // redirect while IDLE with a full buffer
    reset_dut(0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    pulse_redirect(32'h0000_0044);
    chk("idle_redir_req", 32'(bus.imem_req), 32'h1);
    chk("idle_redir_addr", bus.imem_addr, 32'h44);
    bus.inst_ready = 1'b1;
    wait_valid("idle_redir");
    chk("idle_redir_pc", bus.inst_pc, 32'h44);

    // starvation counter with a slow first fetch
    reset_dut(4, 1'b1);
    wait_valid("perf");
`ifdef FETCH_PERF_COUNT_EN
    chk("perf_first", bus.perf_stall_count, 32'd6);
`else
    chk("perf_first", bus.perf_stall_count, 32'd0);
`endif

    // asynchronous reset with 3 buffered entries and a request pending
    reset_dut(3, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 3 && bus.imem_req) break;
    end
    chk("pre_rst_valid", 32'(bus.inst_valid), 32'h1);
    chk("pre_rst_req", 32'(bus.imem_req), 32'h1);
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_valid", 32'(bus.inst_valid), 32'h0);
    chk("async_req", 32'(bus.imem_req), 32'h0);
    chk("async_addr", bus.imem_addr, RESET_PC);
    model_clear();
    lat = 0;
    bus.inst_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    force_ack = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    chk("stray_ack_valid", 32'(bus.inst_valid), 32'h0);
    wait_valid("post_rst");
    chk("post_rst_pc", bus.inst_pc, RESET_PC);
    repeat (4) @(posedge clk);

    mon_en = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
